radix2_sdf_stage: RTL and testbench

- Radix-2 single-path delay-feedback (SDF) butterfly stage of the OFDM FFT datapath.
- Sits directly downstream of the twiddle/sequence ROM and consumes that ROM's state[1:0], w_r and w_i outputs.
- Per accepted sample, the block either fills its delay line, performs the add/subtract butterfly, or drains the stored differences through a complex twiddle multiply.
- Output is a registered complex stream with a valid flag, ready for the next stage.

---
 rtl/fft_pkg.sv | 19 +
 rtl/cmul_sat.sv | 50 +++++
 rtl/radix2_sdf_stage.sv | 128 ++++++++++++
 tb/tb_radix2_sdf_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the OFDM FFT datapath stages: default widths,
// stage-mode encodings from the twiddle/sequence ROM and saturation limits.
package fft_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_FRAC   = 8;

  // Stage mode driven by the sequence ROM; the reserved code behaves like FILL.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2,
    ST_RSVD = 2'd3
  } state_e;

  localparam logic signed [DEF_DATA_W-1:0] MAX_POS = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] MAX_NEG = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/cmul_sat.sv
// Combinational complex multiply y = a * w with Q-format rescale
// (arithmetic shift right by FRAC, i.e. truncation toward -inf) and
// saturation back to DATA_W. Shared by all butterfly stages.
module cmul_sat
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic signed [DATA_W-1:0] a_re_i,
  input  logic signed [DATA_W-1:0] a_im_i,
  input  logic signed [DATA_W-1:0] w_re_i,
  input  logic signed [DATA_W-1:0] w_im_i,
  output logic signed [DATA_W-1:0] y_re_o,
  output logic signed [DATA_W-1:0] y_im_o
);

  localparam int PW = 2 * DATA_W;  // full product width
  localparam int SW = PW + 1;      // sum of two products

  // Clamp a wide signed value to the DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    hi = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi)      sat_wide = hi[DATA_W-1:0];
    else if (v < lo) sat_wide = lo[DATA_W-1:0];
    else             sat_wide = v[DATA_W-1:0];
  endfunction

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] s_re, s_im;
  logic signed [SW-1:0] sh_re, sh_im;

  // Exact products and sums, then rescale and clamp each component.
  always_comb begin
    p_rr   = PW'(a_re_i) * PW'(w_re_i);
    p_ii   = PW'(a_im_i) * PW'(w_im_i);
    p_ri   = PW'(a_re_i) * PW'(w_im_i);
    p_ir   = PW'(a_im_i) * PW'(w_re_i);
    s_re   = SW'(p_rr) - SW'(p_ii);
    s_im   = SW'(p_ri) + SW'(p_ir);
    sh_re  = s_re >>> FRAC;
    sh_im  = s_im >>> FRAC;
    y_re_o = sat_wide(sh_re);
    y_im_o = sat_wide(sh_im);
  end

endmodule

// File: rtl/radix2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage. Depending on the ROM
// mode of each accepted sample it fills the delay line, emits the butterfly
// sum while storing the difference, or drains stored differences through
// a twiddle multiply. One-cycle registered latency, one sample per clock.
module radix2_sdf_stage
  import fft_pkg::*;
#(
  parameter int DELAY  = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);

  // One guard bit is enough for a sum/difference of two DATA_W values.
  function automatic logic signed [DATA_W-1:0] sat1(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      sat1 = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat1 = v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] add_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    add_sat = sat1((DATA_W+1)'(a) + (DATA_W+1)'(b));
  endfunction

  function automatic logic signed [DATA_W-1:0] sub_sat(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    sub_sat = sat1((DATA_W+1)'(a) - (DATA_W+1)'(b));
  endfunction

  // Delay line: index 0 is the head (oldest), new entries enter at DELAY-1.
  logic signed [DATA_W-1:0] dl_r_q [DELAY];
  logic signed [DATA_W-1:0] dl_i_q [DELAY];

  logic signed [DATA_W-1:0] push_r_d, push_i_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] dout_r_q, dout_r_d;
  logic signed [DATA_W-1:0] dout_i_q, dout_i_d;
  logic signed [DATA_W-1:0] tw_r, tw_i;

  cmul_sat #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_cmul (
    .a_re_i (dl_r_q[0]),
    .a_im_i (dl_i_q[0]),
    .w_re_i (w_r),
    .w_im_i (w_i),
    .y_re_o (tw_r),
    .y_im_o (tw_i)
  );

  // Mode decode: choose the value pushed into the delay line and the next output.
  always_comb begin
    push_r_d    = din_r;
    push_i_d    = din_i;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    if (in_valid) begin
      case (state)
        ST_BFLY: begin
          dout_r_d    = add_sat(dl_r_q[0], din_r);
          dout_i_d    = add_sat(dl_i_q[0], din_i);
          push_r_d    = sub_sat(dl_r_q[0], din_r);
          push_i_d    = sub_sat(dl_i_q[0], din_i);
          out_valid_d = 1'b1;
        end
        ST_TWID: begin
          dout_r_d    = tw_r;
          dout_i_d    = tw_i;
          out_valid_d = 1'b1;
        end
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Shift the delay line by one entry per accepted sample; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        dl_r_q[i] <= '0;
        dl_i_q[i] <= '0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < DELAY - 1; i++) begin
        dl_r_q[i] <= dl_r_q[i+1];
        dl_i_q[i] <= dl_i_q[i+1];
      end
      dl_r_q[DELAY-1] <= push_r_d;
      dl_i_q[DELAY-1] <= push_i_d;
    end
  end

  // ---- output register stage ----
  // Output register: valid pulses per produced sample, data holds between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_radix2_sdf_stage.sv
// Bench for radix2_sdf_stage: directed literal sequences plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_radix2_sdf_stage;
  import fft_pkg::*;

  localparam int DELAY  = 2;
  localparam int DATA_W = 24;
  localparam int FRAC   = 8;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]               state;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r, dout_i;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  radix2_sdf_stage #(.DELAY(DELAY), .DATA_W(DATA_W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference model: delay line as a FIFO of complex values.
  longint qr[$];
  longint qi[$];
  bit     m_vld;
  longint m_r, m_i;

  always @(posedge clk or negedge rst_n) begin
    longint ar, ai, br, bi, wr, wi;
    if (!rst_n) begin
      qr = {};
      qi = {};
      for (int k = 0; k < DELAY; k++) begin
        qr.push_back(0);
        qi.push_back(0);
      end
      m_vld = 0;
      m_r   = 0;
      m_i   = 0;
    end else if (in_valid) begin
      ar = qr.pop_front();
      ai = qi.pop_front();
      br = longint'(din_r);
      bi = longint'(din_i);
      wr = longint'(w_r);
      wi = longint'(w_i);
      if (state == 2'd1) begin
        m_r = sat(ar + br);
        m_i = sat(ai + bi);
        qr.push_back(sat(ar - br));
        qi.push_back(sat(ai - bi));
        m_vld = 1;
      end else if (state == 2'd2) begin
        m_r = sat((ar * wr - ai * wi) >>> FRAC);
        m_i = sat((ar * wi + ai * wr) >>> FRAC);
        qr.push_back(br);
        qi.push_back(bi);
        m_vld = 1;
      end else begin
        qr.push_back(br);
        qi.push_back(bi);
        m_vld = 0;
      end
    end else begin
      m_vld = 0;
    end
  end

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_valid", longint'(out_valid), longint'(m_vld));
      chk("model_dout_r", longint'(dout_r), m_r);
      chk("model_dout_i", longint'(dout_i), m_i);
    end
  end

  // Apply one cycle of inputs, returning 1 time unit after the active edge.
  task automatic drive(input bit v, input int st, input longint dr, input longint di,
                       input longint wr, input longint wi);
    in_valid = v;
    state    = 2'(st);
    din_r    = DATA_W'(dr);
    din_i    = DATA_W'(di);
    w_r      = DATA_W'(wr);
    w_i      = DATA_W'(wi);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit v, input longint er, input longint ei);
    chk({name, "_valid"}, longint'(out_valid), longint'(v));
    chk({name, "_r"}, longint'(dout_r), er);
    chk({name, "_i"}, longint'(dout_i), ei);
  endtask

  function automatic longint rnd_data();
    logic signed [DATA_W-1:0] v;
    case ($urandom_range(0, 5))
      0: return MAXV;
      1: return MINV;
      2: return longint'($signed(12'($urandom)));
      default: begin
        v = DATA_W'($urandom);
        return longint'(v);
      end
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; state = 2'd0;
    din_r = '0; din_i = '0; w_r = '0; w_i = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    mon_en = 1;

    // Basic butterfly, w = 1.0
    drive(1, 0, 256, 0, 256, 0);
    drive(1, 0, 512, 0, 256, 0);
    expect_out("fill", 0, 0, 0);
    drive(1, 1, 768, 0, 256, 0);
    expect_out("bfly0", 1, 1024, 0);
    drive(1, 1, 1024, 0, 256, 0);
    expect_out("bfly1", 1, 1536, 0);
    drive(1, 2, 0, 0, 256, 0);
    expect_out("twid0", 1, -512, 0);
    drive(1, 2, 0, 0, 256, 0);
    expect_out("twid1", 1, -512, 0);

    // Twiddle j
    drive(1, 0, 256, 0, 0, 256);
    drive(1, 0, 512, 0, 0, 256);
    drive(1, 1, 768, 0, 0, 256);
    drive(1, 1, 1024, 0, 0, 256);
    drive(1, 2, 0, 0, 0, 256);
    expect_out("twj0", 1, 0, -512);
    drive(1, 2, 0, 0, 0, 256);
    expect_out("twj1", 1, 0, -512);

    // Gaps interleaved
    drive(1, 0, 256, 0, 256, 0);
    drive(0, 1, 9999, 9, 7, 7);
    drive(1, 0, 512, 0, 256, 0);
    drive(0, 2, 1, 1, 1, 1);
    drive(1, 1, 768, 0, 256, 0);
    expect_out("gap_bfly0", 1, 1024, 0);
    drive(0, 1, 5, 5, 5, 5);
    expect_out("gap_hold", 0, 1024, 0);
    drive(1, 1, 1024, 0, 256, 0);
    expect_out("gap_bfly1", 1, 1536, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 256, 0);
    expect_out("gap_twid0", 1, -512, 0);
    drive(0, 2, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 256, 0);
    expect_out("gap_twid1", 1, -512, 0);

    // Saturation
    drive(1, 0, MAXV, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    expect_out("sat_add", 1, MAXV, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, MINV, 0, 0, 0);
    drive(1, 0, MAXV, MAXV, 0, 0);
    drive(1, 2, 0, 0, 256, 0);
    expect_out("sat_twneg", 1, MINV, 0);
    drive(1, 2, 0, 0, 256, 256);
    expect_out("sat_twmul", 1, 0, MAXV);

    // Reserved mode behaves like FILL
    drive(1, 3, 10, 1, 0, 0);
    expect_out("st3a", 0, 0, MAXV);
    drive(1, 3, 20, 2, 0, 0);
    expect_out("st3b", 0, 0, MAXV);
    drive(1, 1, 5, 5, 0, 0);
    expect_out("st3_bfly0", 1, 15, 6);
    drive(1, 1, 5, 5, 0, 0);
    expect_out("st3_bfly1", 1, 25, 7);

    // Reset in the middle of a stream
    drive(1, 0, 3000, 40, 0, 0);
    drive(1, 1, 77, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1, 100, 0, 0, 0);
    expect_out("post_rst", 1, 100, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0)
        drive(1, int'($urandom_range(0, 3)), rnd_data(), rnd_data(),
              rnd_data(), rnd_data());
      else
        drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), rnd_data(), rnd_data(),
              longint'($signed(10'($urandom))), longint'($signed(10'($urandom))));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
